// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract arbiter: default width,
// output-stage state encoding and opcode values.
package addsub_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Output register occupancy: EMPTY means no undelivered result.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_unit.sv
// Combinational adder/subtractor. Subtraction is a + ~b + 1, so the carry
// out is the "no borrow" flag and b = 0 yields carry = 1.
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Invert b and inject the +1 through the carry-in for subtraction.
  always_comb begin
    b_eff    = (sub == OP_SUB) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    c        = sum[WIDTH-1:0];
    carry    = sum[WIDTH];
    // Signed overflow: operands effectively share a sign and the result flips it.
    if (sub == OP_SUB) begin
      overflow = (a[WIDTH-1] != b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
    end else begin
      overflow = (a[WIDTH-1] == b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared add/sub unit with a
// single registered result stage.
//
// Handshake: every channel uses valid/ready. A transfer happens on a rising
// edge where valid and ready are both 1. Valid never depends on ready; the
// request-side ready depends combinationally on rsp_ready (drain and refill
// in the same cycle) but rsp_* never depend combinationally on req*_valid.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output state_e           dbg_state
);

  state_e           state;
  state_e           state_next;
  logic             last_grant;
  logic             grant_id;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_sub;
  logic [WIDTH-1:0] unit_c;
  logic             unit_carry;
  logic             unit_overflow;

  // Round-robin grant and request-side ready; ready is forced low in reset.
  always_comb begin
    grant_id   = 1'b0;
    can_accept = (state == EMPTY) || rsp_ready;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
    req0_ready = rst_n && can_accept && req0_valid && !grant_id;
    req1_ready = rst_n && can_accept && req1_valid &&  grant_id;
    xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel_a      = grant_id ? req1_a   : req0_a;
    sel_b      = grant_id ? req1_b   : req0_b;
    sel_sub    = grant_id ? req1_sub : req0_sub;
  end

  addsub_unit #(.WIDTH(WIDTH)) u_unit (
    .a        (sel_a),
    .b        (sel_b),
    .sub      (sel_sub),
    .c        (unit_c),
    .carry    (unit_carry),
    .overflow (unit_overflow)
  );

  // Output occupancy next-state: fill on transfer, empty on drain without refill.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (xfer) state_next = FULL;
      FULL:    if (rsp_ready && !xfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // State register and last-grant memory (reset so requester 0 wins first tie).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (xfer) begin
        last_grant <= grant_id;
      end
    end
  end

  // Result register: loads only on a transfer, otherwise holds its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_c        <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_id       <= 1'b0;
    end else if (xfer) begin
      rsp_c        <= unit_c;
      rsp_carry    <= unit_carry;
      rsp_overflow <= unit_overflow;
      rsp_id       <= grant_id;
    end
  end

  assign rsp_valid = (state == FULL);
  assign dbg_state = state;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter: a table of single-requester operations
// plus hand-written round-robin, backpressure and mid-operation reset sequences.
module tb_addsub_arbiter;
  import addsub_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_overflow;
  logic [W-1:0] rsp_c;
  state_e       dbg_state;

  int total;
  int bad;

  typedef struct {
    logic         who;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] c;
    logic         carry;
    logic         ov;
  } vec_t;

  vec_t vecs[10];

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_sub     (req0_sub),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_sub     (req1_sub),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_c        (rsp_c),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one requester valid with operands; the other is idle.
  task automatic drive_one(input logic who, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub);
    req0_valid = (who == 1'b0);
    req1_valid = (who == 1'b1);
    if (who == 1'b0) begin
      req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_a = a; req1_b = b; req1_sub = sub;
    end
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'h8000_0000, 32'h0000_0000, OP_SUB, 32'h8000_0000, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0005, 32'h0000_0007, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h1234_5678, 32'h1111_1111, OP_ADD, 32'h2345_6789, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, OP_SUB, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, OP_SUB, 32'h8000_0000, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 32'h0000_0003, 32'h0000_0003, OP_SUB, 32'h0000_0000, 1'b1, 1'b0};

    // Reset with requester 0 already asking: ready must stay low.
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_c", rsp_c, 0);
    chk("reset_state", dbg_state, EMPTY);
    chk("reset_req0_ready", req0_ready, 0);
    chk("reset_id_flags", {rsp_id, rsp_carry, rsp_overflow}, 0);

    // Release reset; first transfer on the very next edge.
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-requester operations, one per cycle.
    for (int i = 0; i < 10; i++) begin
      drive_one(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].sub);
      #1;
      chk($sformatf("v%0d_ready0", i), req0_ready, (vecs[i].who == 1'b0));
      chk($sformatf("v%0d_ready1", i), req1_ready, (vecs[i].who == 1'b1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), rsp_valid, 1);
      chk($sformatf("v%0d_c", i), rsp_c, vecs[i].c);
      chk($sformatf("v%0d_carry", i), rsp_carry, vecs[i].carry);
      chk($sformatf("v%0d_ov", i), rsp_overflow, vecs[i].ov);
      chk($sformatf("v%0d_id", i), rsp_id, vecs[i].who);
      @(negedge clk);
    end

    // Drain, then reset so the round-robin test starts fresh.
    idle_reqs();
    @(posedge clk);
    #1;
    chk("drain_empty", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin: both valid for 4 edges -> grants 0,1,0,1.
    req0_a = 32'd10; req0_b = 32'd1; req0_sub = OP_ADD;
    req1_a = 32'd10; req1_b = 32'd1; req1_sub = OP_SUB;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_ready0", k), req0_ready, (k % 2 == 0));
      chk($sformatf("rr%0d_ready1", k), req1_ready, (k % 2 == 1));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_valid", k), rsp_valid, 1);
      chk($sformatf("rr%0d_id", k), rsp_id, (k % 2 == 1));
      chk($sformatf("rr%0d_c", k), rsp_c, (k % 2 == 1) ? 32'd9 : 32'd11);
      @(negedge clk);
    end

    // Drain to EMPTY before the backpressure sequence.
    idle_reqs();
    @(posedge clk);
    #1;
    chk("rr_drain", rsp_valid, 0);
    @(negedge clk);

    // Backpressure: one transfer, then stall for 3 cycles with stable outputs.
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("bp_first_ready0", req0_ready, 1);
    @(posedge clk);
    #1;
    chk("bp_loaded_id", rsp_id, 0);
    chk("bp_loaded_c", rsp_c, 32'd11);
    @(negedge clk);
    // Changing operands after the transfer must not disturb the held result.
    req0_a = 32'd100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_ready0", k), req0_ready, 0);
      chk($sformatf("bp%0d_ready1", k), req1_ready, 0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
      chk($sformatf("bp%0d_c", k), rsp_c, 32'd11);
      chk($sformatf("bp%0d_id", k), rsp_id, 0);
      @(negedge clk);
    end
    // Release: drain and refill in one edge; requester 1 is next in turn.
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready1", req1_ready, 1);
    chk("bp_release_ready0", req0_ready, 0);
    @(posedge clk);
    #1;
    chk("bp_refill_valid", rsp_valid, 1);
    chk("bp_refill_id", rsp_id, 1);
    chk("bp_refill_c", rsp_c, 32'd9);
    chk("bp_refill_state", dbg_state, FULL);

    // Mid-operation reset while FULL: result discarded immediately.
    @(negedge clk);
    idle_reqs();
    rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", rsp_valid, 0);
    chk("mid_reset_c", rsp_c, 0);
    chk("mid_reset_ready1", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_a = 32'h0000_0002; req0_b = 32'h0000_0003; req0_sub = OP_ADD;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("post_reset_tie_ready0", req0_ready, 1);
    @(posedge clk);
    #1;
    chk("post_reset_id", rsp_id, 0);
    chk("post_reset_c", rsp_c, 32'd5);
    @(negedge clk);
    idle_reqs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req0_sub  input  1  requester 0 opcode, 0 = a+b, 1 = a-b.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sub  same directions, widths and meanings as requester 0, for requester 1.
REQ-009 rsp_valid  output  1  result register holds an undelivered result.
REQ-010 rsp_ready  input  1  consumer accepts the result this cycle.
REQ-011 rsp_id  output  1  requester index that owns the result.
REQ-012 rsp_c  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 rsp_carry  output  1  carry out of bit WIDTH-1 of a + (sub ? ~b : b) + sub.
REQ-014 rsp_overflow  output  1  signed two's-complement overflow of the operation.

Function
REQ-015 Output FSM SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 can_accept SHALL equal (state==EMPTY) or (state==FULL and rsp_ready==1).
REQ-017 A transfer occurs on requester N when reqN_valid and reqN_ready are both 1 at a rising edge.
REQ-018 Arbitration SHALL be round-robin. If exactly one requester is valid, that requester is granted. If both are valid, the requester not granted most recently is granted.
REQ-019 reqN_ready SHALL be 1 only when can_accept is 1 and requester N is granted; at most one ready is asserted per cycle.
REQ-020 The last-grant register SHALL update only on a transfer.
REQ-021 Latency SHALL be exactly one cycle: a transfer at edge k makes rsp_valid=1 with the corresponding rsp_c/rsp_carry/rsp_id/rsp_overflow after edge k.
REQ-022 Subtraction SHALL compute a + ~b + 1. For b = 0 this gives c = a, carry = 1, overflow = 0 (including b = 0 with any a).
REQ-023 Overflow for add SHALL be (a[W-1]==b[W-1]) and (c[W-1]!=a[W-1]). Overflow for sub SHALL be (a[W-1]!=b[W-1]) and (c[W-1]!=a[W-1]).
REQ-024 In FULL with rsp_ready=0, all rsp_* outputs SHALL hold stable and no transfer occurs.
REQ-025 A simultaneous drain and transfer in FULL SHALL keep the state FULL and load the new result, giving one operation per cycle of sustained throughput.
REQ-026 A drain with no transfer SHALL move the state to EMPTY. A transfer in EMPTY SHALL move the state to FULL.
REQ-027 Requester inputs SHALL be sampled only at the transfer edge; later changes do not affect the result.
REQ-028 There SHALL be no combinational path from reqN_valid to rsp_*. A combinational path from rsp_ready to reqN_ready is permitted.

Reset
REQ-029 While rst_n=0, the block SHALL hold state=EMPTY, rsp_valid=0, rsp_c=0, rsp_carry=0, rsp_overflow=0, rsp_id=0, and last-grant=1 (requester 0 wins the first tie).
REQ-030 An assertion of reset mid-operation SHALL discard any held result. req0_ready and req1_ready SHALL be 0 during reset.
REQ-031 The first transfer SHALL be possible at the first rising edge after rst_n deasserts.

Structure
REQ-032 A shared package addsub_pkg SHALL hold the WIDTH default, the state enum {EMPTY, FULL}, and the opcode constants OP_ADD=0 and OP_SUB=1.
REQ-033 One combinational sub-module, addsub_unit, SHALL be instantiated once. Its inputs are a, b and sub. Its outputs are c, carry and overflow.
REQ-034 The arbiter and output register SHALL reside in addsub_arbiter.

Verification
REQ-035 Add overflow: req0 only, a=0x7FFFFFFF, b=1, sub=0, rsp_ready=1 -> next cycle rsp_c=0x80000000, overflow=1, carry=0, rsp_id=0.
REQ-036 Sub with zero b: req1 only, a=0x80000000, b=0, sub=1 -> rsp_c=0x80000000, carry=1, overflow=0, rsp_id=1.
REQ-037 Sub overflow: a=0x80000000, b=1, sub=1 -> rsp_c=0x7FFFFFFF, overflow=1.
REQ-038 Round-robin: both requesters valid continuously for 4 cycles after reset with rsp_ready=1 -> grants 0,1,0,1; rsp_valid=1 on cycles 2-5.
REQ-039 Backpressure: rsp_ready=0 for 3 cycles with both requesters valid -> exactly one transfer, rsp_* stable, req0_ready=req1_ready=0 while FULL. Raising rsp_ready -> drain and new transfer in the same cycle.
REQ-040 Reset mid-operation: pull rst_n low while FULL -> rsp_valid=0 immediately. After release, a tie is granted to requester 0.
